// File: rtl/order_pkg.sv
// Shared types and helpers for the order-to-UART framer.
// The checksum helper is only referenced when ORDER_FRAMER_CKSUM_EN is defined.
package order_pkg;

  typedef enum logic {SIDE_BUY, SIDE_SELL} side_e;

  typedef struct packed {
    side_e       side;
    logic [31:0] price;
    logic [15:0] qty;
  } order_t;

  localparam logic [7:0] CHAR_BUY       = 8'h42;
  localparam logic [7:0] CHAR_SELL      = 8'h53;
  localparam int         FRAME_LEN_BASE = 8;

  typedef enum logic {IDLE, SEND} framer_state_e;

  // ASCII marker for the order side
  function automatic logic [7:0] side_char(input side_e s);
    return (s == SIDE_SELL) ? CHAR_SELL : CHAR_BUY;
  endfunction

  // XOR over side char, price and qty bytes; the SOF marker is excluded
  function automatic logic [7:0] order_cksum(input order_t o);
    return side_char(o.side)
         ^ o.price[31:24] ^ o.price[23:16] ^ o.price[15:8] ^ o.price[7:0]
         ^ o.qty[15:8] ^ o.qty[7:0];
  endfunction

endpackage

// File: rtl/order_tx_framer.sv
// order_tx_framer: serialises one latched order (side, price, qty) into a byte
// frame for uart_tx. Frame: SOF, side char, price (big-endian), qty (big-endian),
// plus a trailing XOR checksum byte when ORDER_FRAMER_CKSUM_EN is defined.
// Upstream is back-pressured (order_ready=0) for the whole frame.
module order_tx_framer
  import order_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE = 8'hA5,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             order_valid,
  output logic             order_ready,
  input  logic             order_side,
  input  logic [31:0]      order_price,
  input  logic [15:0]      order_qty,
  output logic [7:0]       tx_byte,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

`ifdef ORDER_FRAMER_CKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_BASE + 1;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  framer_state_e    state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] count_q;
  logic             count_inc;
  logic             load;
  order_t           hold_q;
  logic [7:0]       frame_byte;

  // Control state: FSM state, byte index and completed-frame counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (count_inc) count_q <= count_q + CNT_W'(1);
    end
  end

  // Hold register: captured on acceptance, deliberately not reset (data path)
  always_ff @(posedge clk) begin
    if (load) hold_q <= '{side: side_e'(order_side), price: order_price, qty: order_qty};
  end

  // Byte selection from the held order by frame position
  always_comb begin
    frame_byte = 8'h00;
    case (idx_q)
      4'd0: frame_byte = SOF_BYTE;
      4'd1: frame_byte = side_char(hold_q.side);
      4'd2: frame_byte = hold_q.price[31:24];
      4'd3: frame_byte = hold_q.price[23:16];
      4'd4: frame_byte = hold_q.price[15:8];
      4'd5: frame_byte = hold_q.price[7:0];
      4'd6: frame_byte = hold_q.qty[15:8];
      4'd7: frame_byte = hold_q.qty[7:0];
`ifdef ORDER_FRAMER_CKSUM_EN
      4'd8: frame_byte = order_cksum(hold_q);
`endif
      default: frame_byte = 8'h00;
    endcase
  end

  // Next-state and handshake outputs; tx_byte is forced to zero outside SEND
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    load        = 1'b0;
    count_inc   = 1'b0;
    order_ready = 1'b0;
    tx_valid    = 1'b0;
    tx_byte     = 8'h00;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        order_ready = 1'b1;
        if (order_valid) begin
          load    = 1'b1;
          idx_d   = 4'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_byte  = frame_byte;
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d   = IDLE;
            idx_d     = 4'd0;
            count_inc = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_count = count_q;

endmodule
